// File: rtl/dcache_responder.sv
// Direct-mapped, one-word-per-line, write-through, no-write-allocate data cache responder.
// Optional hit/miss statistics are built when DCACHE_STATS_EN is defined.
module dcache_responder #(
  parameter int unsigned LINES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dcache_addr,
  input  logic        dcache_re,
  input  logic [3:0]  dcache_we,
  input  logic [31:0] dcache_din,
  output logic [31:0] dcache_dout,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_rw,
  output logic [29:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  output logic [3:0]  mem_req_mask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = 30 - IW;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOOKUP  = 3'd1;
  localparam logic [2:0] S_RD_REQ  = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_WR_REQ  = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [29:0]      waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       mask_q, mask_d;
  logic             is_wr_q, is_wr_d;
  logic [31:0]      resp_q, resp_d;
  logic [LINES-1:0] valid_q, valid_d;

  logic [31:0]      data_mem [LINES];
  logic [TW-1:0]    tag_mem  [LINES];
  logic [31:0]      rd_data_q;
  logic [TW-1:0]    rd_tag_q;

  logic             arr_we, tag_we, rd_en;
  logic [3:0]       arr_be;
  logic [31:0]      arr_wdata;
  logic [IW-1:0]    idx_q;
  logic             tag_match, rd_hit, can_accept, req_any;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^dcache_addr[1:0];

  assign idx_q      = waddr_q[IW-1:0];
  assign tag_match  = valid_q[idx_q] && (rd_tag_q == waddr_q[29:IW]);
  assign rd_hit     = (state_q == S_LOOKUP) && !is_wr_q && tag_match;
  assign can_accept = (state_q == S_IDLE) || (state_q == S_RESP) || rd_hit;
  assign req_any    = dcache_re || (dcache_we != 4'b0000);

  always_comb begin
    state_d   = state_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    mask_d    = mask_q;
    is_wr_d   = is_wr_q;
    resp_d    = resp_q;
    valid_d   = valid_q;
    arr_we    = 1'b0;
    tag_we    = 1'b0;
    rd_en     = 1'b0;
    arr_be    = '0;
    arr_wdata = wdata_q;

    case (state_q)
      S_LOOKUP: begin
        if (is_wr_q) begin
          if (tag_match) begin
            arr_we = 1'b1;
            arr_be = mask_q;
          end
          state_d = S_WR_REQ;
        end else if (!tag_match) begin
          state_d = S_RD_REQ;
        end
      end
      S_RD_REQ:  if (mem_req_ready) state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (mem_resp_valid) begin
          arr_we          = 1'b1;
          arr_be          = '1;
          arr_wdata       = mem_resp_data;
          tag_we          = 1'b1;
          valid_d[idx_q]  = 1'b1;
          resp_d          = mem_resp_data;
          state_d         = S_RESP;
        end
      end
      S_WR_REQ:  if (mem_req_ready) state_d = S_RESP;
      S_IDLE, S_RESP: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // A read hit in LOOKUP frees the pipeline, so a new request may be taken that same cycle.
    if (can_accept) begin
      if (req_any) begin
        waddr_d = dcache_addr[31:2];
        wdata_d = dcache_din;
        mask_d  = dcache_we;
        is_wr_d = (dcache_we != 4'b0000);
        rd_en   = 1'b1;
        state_d = S_LOOKUP;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      waddr_q <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      is_wr_q <= 1'b0;
      resp_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      is_wr_q <= is_wr_d;
      resp_q  <= resp_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (arr_we && arr_be[b]) data_mem[idx_q][8*b +: 8] <= arr_wdata[8*b +: 8];
    end
    if (tag_we) tag_mem[idx_q] <= waddr_q[29:IW];
    if (rd_en) begin
      rd_data_q <= data_mem[dcache_addr[IW+1:2]];
      rd_tag_q  <= tag_mem[dcache_addr[IW+1:2]];
    end
  end

  assign stall = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT) || (state_q == S_WR_REQ) ||
                 ((state_q == S_LOOKUP) && !rd_hit);
  assign dcache_dout   = (state_q == S_LOOKUP) ? rd_data_q : resp_q;
  assign mem_req_valid = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
  assign mem_req_rw    = (state_q == S_WR_REQ);
  assign mem_req_addr  = waddr_q;
  assign mem_req_data  = wdata_q;
  assign mem_req_mask  = (state_q == S_WR_REQ) ? mask_q : 4'b0000;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if ((state_q == S_LOOKUP) && !is_wr_q) begin
      if (tag_match) hit_cnt_d  = hit_cnt_q + 32'd1;
      else           miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: doc/dcache_responder.md
# dcache_responder

Memory-side responder for the CPU data port. Accepts the CPU's dcache requests (address, read enable, byte write mask, write data) and returns read data with a `stall` handshake. Internally a direct-mapped, one-word-per-line, write-through, no-write-allocate cache in front of a valid/ready main-memory interface. Sits between the CPU top's dcache ports and the memory arbiter.

## Interface
- `LINES`, 64: number of cache lines; power of two; index width `IW = log2(LINES)`.
- `clk`  in  1  sole clock; everything is rising-edge.
- `reset`  in  1  synchronous, active-high.
- `dcache_addr`  in  32  byte address; `[1:0]` ignored; index `[IW+1:2]`, tag `[31:IW+2]`.
- `dcache_re`  in  1  read request.
- `dcache_we`  in  4  byte write mask; nonzero = write request; write has priority over `dcache_re`.
- `dcache_din`  in  32  write data.
- `dcache_dout`  out  32  read data.
- `stall`  out  1  CPU must freeze and hold request inputs while high.
- `mem_req_valid`  out  1  memory request valid.
- `mem_req_ready`  in  1  memory accepts the request this cycle.
- `mem_req_rw`  out  1  1 = write, 0 = read.
- `mem_req_addr`  out  30  word address (`dcache_addr[31:2]`).
- `mem_req_data`  out  32  write data.
- `mem_req_mask`  out  4  byte mask (0 for reads).
- `mem_resp_valid`  in  1  read data valid (one pulse per read request).
- `mem_resp_data`  in  32  read data.
- `hit_count`, `miss_count`  out  32 each  statistics (see Configuration).

## Operation
- Storage: data and tag arrays, synchronous read (data available the cycle after address); valid bits in flops.
- States: IDLE, LOOKUP, RD_REQ, RD_WAIT, WR_REQ, RESP.
- Acceptance: in IDLE, RESP, and LOOKUP-with-read-hit, a request (`dcache_re` or `dcache_we != 0`) is captured (addr, data, mask, kind), arrays read → LOOKUP. No request → IDLE.
- LOOKUP, read hit (valid and tag match): `dcache_dout` = array data, `stall` = 0; next request accepted the same cycle.
- LOOKUP, read miss: `stall` = 1 → RD_REQ.
- LOOKUP, write: on hit, array bytes selected by mask are updated this cycle (tag/valid unchanged); on miss, no array change. `stall` = 1 → WR_REQ.
- RD_REQ: `mem_req_valid` = 1, `rw` = 0, mask 0; on `mem_req_ready` → RD_WAIT.
- RD_WAIT: on `mem_resp_valid`, line filled (data, tag, valid = 1) and response data registered → RESP.
- WR_REQ: `mem_req_valid` = 1, `rw` = 1, captured data/mask; on `mem_req_ready` → RESP.
- RESP: `stall` = 0; `dcache_dout` = fill data after a read (undefined after a write); acts as acceptance state.
- `mem_req_*` payload held stable while `mem_req_valid` high and not ready.
- `mem_resp_valid` outside RD_WAIT ignored.
- CPU inputs are ignored in LOOKUP-with-stall, RD_REQ, RD_WAIT, WR_REQ (CPU holds them by contract).

## Timing
- Reset: state IDLE, all valid bits 0, `stall` 0, `mem_req_valid` 0, `dcache_dout` 0, counters 0. Reset mid-transaction abandons it; `mem_req_valid` drops the next cycle; a late response is ignored.
- `stall` is combinational from state and hit compare: 1 in RD_REQ, RD_WAIT, WR_REQ, and LOOKUP unless read hit; else 0.
- Read hit: request at cycle N → data and `stall` = 0 at N+1. Back-to-back hits sustain one per cycle.
- Read miss, ready at once, response k cycles after handshake: request N, `mem_req_valid` N+2, data with `stall` = 0 at N+3+k.
- Write, ready at once: request N, `mem_req_valid` N+2, `stall` = 0 at N+3.
- Write hit followed by read of same address: read returns merged data.

## Configuration
- `DCACHE_STATS_EN` defined: `hit_count` increments on each LOOKUP read hit, `miss_count` on each LOOKUP read miss; writes not counted; 32-bit wrap; cleared by reset.
- Undefined: counter logic absent; both ports tied to 0.

## Test plan
- Reset, read 0x0000_0100 → miss; mem responds 0xDEAD_BEEF after 3 cycles → `dcache_dout` 0xDEAD_BEEF, `stall` low exactly as in Timing; repeat read → hit at N+1, no memory request.
- Write 0x0000_0100 mask 4'b0011 data 0x0000_1234 after fill → memory write with mask 0011; subsequent read → 0xDEAD_1234 from cache.
- Write miss to 0x0000_0200 → memory write issued, then read 0x0000_0200 → miss (no allocate).
- Conflict: fill 0x0000_0100, then read 0x0000_0200 + LINES*4 mapping to same index → miss evicts; reread 0x0000_0100 → miss.
- `mem_req_ready` held low 5 cycles → payload stable, `stall` high throughout; reset asserted during RD_WAIT → IDLE, late `mem_resp_valid` ignored, valid bits clear.
- With `DCACHE_STATS_EN`: 3 hits, 2 misses, 1 write → `hit_count` 3, `miss_count` 2; without: both 0.
